dsp_gpio_boot_seq: RTL



---
 rtl/dsp_gpio_boot_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/dsp_gpio_boot_seq.sv
// dsp_gpio_boot_seq
//   Steps the DSP GPIO bank through the DSP boot sequence. It holds the DSP
//   in reset while a latched boot-mode word is strapped onto the pins, then
//   releases reset and keeps the strap driven for a short time. After that it
//   waits for the DSP to report boot-config-done and retries on timeout.
//   In RUN it applies the DSP-programmed pin directions and stretches the PRI
//   and GPS PPS events onto their dedicated pins.
// Ports:
//   clk, rstn          system clock, asynchronous active-low reset
//   i_bootmode         boot-mode strap word, latched once per boot attempt
//   i_dir_cfg          run-time pin direction, 1 = FPGA drives the pin
//   i_bootconfig_done  DSP boot complete (asynchronous level)
//   i_pri_pulse        PRI timing event (asynchronous, rising edge)
//   i_gps_pps          GPS PPS event (asynchronous, rising edge)
//   i_retry            single-cycle pulse that restarts the sequence from FAIL
//   o_gpio_oe          per-pin output enable to the pad
//   o_gpio_out         per-pin output value to the pad
//   o_dsp_rstn         DSP reset, active-low
//   o_boot_ok          high in RUN
//   o_boot_err         high in FAIL
//   o_state            IDLE=0 HOLD=1 RELEASE=2 WAIT=3 RUN=4 FAIL=5
//   o_retry_cnt        retries consumed in the current sequence
module dsp_gpio_boot_seq #(
  parameter int unsigned RST_HOLD_CYC  = 64,
  parameter int unsigned BOOT_HOLD_CYC = 32,
  parameter int unsigned DONE_TIMEOUT  = 4096,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned PULSE_W       = 8,
  parameter int unsigned PRI_BIT       = 0,
  parameter int unsigned PPS_BIT       = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] i_bootmode,
  input  logic [15:0] i_dir_cfg,
  input  logic        i_bootconfig_done,
  input  logic        i_pri_pulse,
  input  logic        i_gps_pps,
  input  logic        i_retry,
  output logic [15:0] o_gpio_oe,
  output logic [15:0] o_gpio_out,
  output logic        o_dsp_rstn,
  output logic        o_boot_ok,
  output logic        o_boot_err,
  output logic [2:0]  o_state,
  output logic [3:0]  o_retry_cnt
);

  localparam int unsigned MAX_A = (RST_HOLD_CYC > BOOT_HOLD_CYC) ? RST_HOLD_CYC : BOOT_HOLD_CYC;
  localparam int unsigned MAX_B = (DONE_TIMEOUT > PULSE_W) ? DONE_TIMEOUT : PULSE_W;
  localparam int unsigned MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_HOLD_CYC - 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_W);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [15:0]   PRI_MASK  = 16'(1) << PRI_BIT;
  localparam logic [15:0]   PPS_MASK  = 16'(1) << PPS_BIT;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RELEASE = 3'd2,
    S_WAIT    = 3'd3,
    S_RUN     = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pri_cnt, pps_cnt;
  logic [3:0]    retry_cnt;
  logic [15:0]   r_boot;
  logic [15:0]   dir_q;
  logic [1:0]    done_sr;
  logic [2:0]    pri_sr, pps_sr;
  logic          boot_latch, retry_inc, retry_clr;
  logic          done_s, pri_rise, pps_rise;

  assign done_s   = done_sr[1];
  assign pri_rise = pri_sr[1] & ~pri_sr[2];
  assign pps_rise = pps_sr[1] & ~pps_sr[2];

  // Synchronizers; the third stage of PRI/PPS is the edge-detect history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_sr <= '0;
      pri_sr  <= '0;
      pps_sr  <= '0;
    end else begin
      done_sr <= {done_sr[0], i_bootconfig_done};
      pri_sr  <= {pri_sr[1:0], i_pri_pulse};
      pps_sr  <= {pps_sr[1:0], i_gps_pps};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      retry_cnt <= '0;
      r_boot    <= '0;
      dir_q     <= '0;
      pri_cnt   <= '0;
      pps_cnt   <= '0;
    end else begin
      state <= state_n;
      dir_q <= i_dir_cfg;

      if (state_n != state)
        cnt <= '0;
      else if (state == S_HOLD || state == S_RELEASE || state == S_WAIT)
        cnt <= cnt + CW'(1);

      if (retry_clr)
        retry_cnt <= '0;
      else if (retry_inc)
        retry_cnt <= retry_cnt + 4'd1;

      if (boot_latch)
        r_boot <= i_bootmode;

      // Stretchers only run in RUN, so edges seen earlier are dropped and
      // the counters start from zero on RUN entry.
      if (state != S_RUN)
        pri_cnt <= '0;
      else if (pri_rise)
        pri_cnt <= PULSE_LD;
      else if (pri_cnt != '0)
        pri_cnt <= pri_cnt - CW'(1);

      if (state != S_RUN)
        pps_cnt <= '0;
      else if (pps_rise)
        pps_cnt <= PULSE_LD;
      else if (pps_cnt != '0)
        pps_cnt <= pps_cnt - CW'(1);
    end
  end

  always_comb begin
    state_n    = state;
    boot_latch = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        state_n    = S_HOLD;
        boot_latch = 1'b1;
      end
      S_HOLD:    if (cnt == RST_LAST)  state_n = S_RELEASE;
      S_RELEASE: if (cnt == BOOT_LAST) state_n = S_WAIT;
      S_WAIT: begin
        if (done_s) begin
          state_n = S_RUN;
        end else if (cnt == DONE_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            state_n    = S_HOLD;
            retry_inc  = 1'b1;
            boot_latch = 1'b1;
          end else begin
            state_n = S_FAIL;
          end
        end
      end
      S_RUN: state_n = S_RUN;
      S_FAIL: begin
        if (i_retry) begin
          state_n   = S_IDLE;
          retry_clr = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    o_gpio_oe  = '0;
    o_gpio_out = '0;
    o_dsp_rstn = 1'b0;
    o_boot_ok  = 1'b0;
    o_boot_err = 1'b0;
    case (state)
      S_HOLD: begin
        o_gpio_oe  = '1;
        o_gpio_out = r_boot;
      end
      S_RELEASE: begin
        o_dsp_rstn = 1'b1;
        o_gpio_oe  = '1;
        o_gpio_out = r_boot;
      end
      S_WAIT: o_dsp_rstn = 1'b1;
      S_RUN: begin
        o_dsp_rstn = 1'b1;
        o_boot_ok  = 1'b1;
        o_gpio_oe  = dir_q;
        o_gpio_out = ((pri_cnt != '0) ? PRI_MASK : '0) |
                     ((pps_cnt != '0) ? PPS_MASK : '0);
      end
      S_FAIL: o_boot_err = 1'b1;
      default: ;
    endcase
  end

  assign o_state     = state;
  assign o_retry_cnt = retry_cnt;

endmodule
